// File: rtl/bus_slave_mem.sv
// bus_slave_mem: memory-backed responder on the switch-internal master bus.
// Serves one write or read burst at a time. Each beat is acknowledged by a
// single-cycle registered ready pulse after a programmable wait. Beats whose
// word index lies beyond the memory set a sticky address-error flag.
module bus_slave_mem #(
    parameter int              AW       = 12,
    parameter int              DW       = 14,
    parameter int              SW       = 4,
    parameter logic [SW-1:0]   SLV_ID   = 4'h1,
    parameter int              WAIT_CYC = 0,
    parameter int              DEPTH    = 1024
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iSlvWrReq,
    input  logic          iSlvWrValid,
    input  logic [AW-1:0] iSlvWrAddr,
    input  logic [SW-1:0] iSlvWrSel,
    input  logic          iSlvWrLast,
    input  logic [DW-1:0] iSlvWrData,
    output logic          oSlvWrReady,
    input  logic          iSlvRdReq,
    input  logic          iSlvRdValid,
    input  logic [AW-1:0] iSlvRdAddr,
    input  logic [SW-1:0] iSlvRdSel,
    input  logic          iSlvRdLast,
    output logic          oSlvRdReady,
    output logic [DW-1:0] oSlvRdData,
    output logic          oSlvAddrErr
);

    localparam int IW = AW - 2;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_wrReady;
    logic            r_rdReady;
    logic [DW-1:0]   r_rdData;
    logic            r_addrErr;
    logic [DW-1:0]   r_mem [DEPTH];

    logic [IW-1:0]   w_wrIdx;
    logic [IW-1:0]   w_rdIdx;
    logic            w_wrInRange;
    logic            w_rdInRange;
    logic            w_wrBeat;
    logic            w_rdBeat;
    logic            w_wrAccept;
    logic            w_rdAccept;
    logic            w_cntDone;
    logic            w_unusedAddrBits;

    // Byte addresses select whole words; the low two bits carry no meaning here.
    assign w_wrIdx          = iSlvWrAddr[AW-1:2];
    assign w_rdIdx          = iSlvRdAddr[AW-1:2];
    assign w_unusedAddrBits = ^{iSlvWrAddr[1:0], iSlvRdAddr[1:0]};
    assign w_wrInRange      = (32'(w_wrIdx) < 32'(DEPTH));
    assign w_rdInRange      = (32'(w_rdIdx) < 32'(DEPTH));

    // A beat only counts while it is valid and addressed to this slave.
    assign w_wrBeat   = iSlvWrValid && (iSlvWrSel == SLV_ID);
    assign w_rdBeat   = iSlvRdValid && (iSlvRdSel == SLV_ID);
    assign w_wrAccept = (r_state == WR_BURST) && iSlvWrReq && r_wrReady && w_wrBeat;
    assign w_rdAccept = (r_state == RD_BURST) && iSlvRdReq && r_rdReady && w_rdBeat;
    assign w_cntDone  = (r_cnt == 4'(WAIT_CYC));

    assign oSlvWrReady = r_wrReady;
    assign oSlvRdReady = r_rdReady;
    assign oSlvRdData  = r_rdData;
    assign oSlvAddrErr = r_addrErr;

    // Burst FSM with wait counter, registered ready pulses, read data and error flag.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wrReady <= 1'b0;
            r_rdReady <= 1'b0;
            r_rdData  <= '0;
            r_addrErr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_wrReady <= 1'b0;
                    r_rdReady <= 1'b0;
                    if (iSlvWrReq && (iSlvWrSel == SLV_ID)) begin
                        r_state <= WR_BURST;
                    end else if (iSlvRdReq && (iSlvRdSel == SLV_ID)) begin
                        r_state <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (!iSlvWrReq) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_wrReady <= 1'b0;
                    end else if (w_wrAccept) begin
                        r_cnt     <= '0;
                        r_wrReady <= 1'b0;
                        if (!w_wrInRange) begin
                            r_addrErr <= 1'b1;
                        end
                        if (iSlvWrLast) begin
                            r_state <= IDLE;
                        end
                    end else if (!w_wrBeat) begin
                        r_cnt     <= '0;
                        r_wrReady <= 1'b0;
                    end else if (w_cntDone) begin
                        r_wrReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RD_BURST: begin
                    if (!iSlvRdReq) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_rdReady <= 1'b0;
                    end else if (w_rdAccept) begin
                        r_cnt     <= '0;
                        r_rdReady <= 1'b0;
                        if (w_rdInRange) begin
                            r_rdData <= r_mem[w_rdIdx];
                        end else begin
                            r_rdData  <= '0;
                            r_addrErr <= 1'b1;
                        end
                        if (iSlvRdLast) begin
                            r_state <= IDLE;
                        end
                    end else if (!w_rdBeat) begin
                        r_cnt     <= '0;
                        r_rdReady <= 1'b0;
                    end else if (w_cntDone) begin
                        r_rdReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_wrReady <= 1'b0;
                    r_rdReady <= 1'b0;
                end
            endcase
        end
    end

    // Memory array is deliberately not reset; only accepted in-range writes land.
    always_ff @(posedge iClk) begin
        if (w_wrAccept && w_wrInRange) begin
            r_mem[w_wrIdx] <= iSlvWrData;
        end
    end

endmodule
